// File: rtl/t1_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module   : t1_bist_driver
//  Purpose  : Built-in self-test driver for the t1 PLA logic cone (21 inputs,
//             1 output). Applies pseudo-random (or exhaustive counting)
//             stimulus to the cone, compacts the serial cone response into a
//             CRC signature and compares it against an expected signature.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             start_i    - start pulse, honoured in IDLE or DONE only
//             num_vec_i  - number of vectors, sampled on accepted start
//             exp_sig_i  - expected signature, sampled on accepted start
//             x_o        - stimulus to cone inputs (bit k drives xk)
//             y_i        - cone response, combinational from x_o
//             busy_o     - high while vectors are being applied
//             done_o     - high once the run completes, until next start
//             sig_o      - current signature
//             pass_o     - in DONE: signature matched expected value
//  Config   : T1_BIST_EXHAUSTIVE_EN - when defined, the stimulus is a binary
//             up-counter from SEED instead of the Fibonacci LFSR.
//  Revision : 1.0 - initial release
// ============================================================================
module t1_bist_driver #(
  parameter int                NUM_IN    = 21,
  parameter logic [NUM_IN-1:0] LFSR_TAPS = 21'h140000,
  parameter logic [NUM_IN-1:0] SEED      = 21'h000001,
  parameter int                SIG_W     = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SIG_INIT  = 16'hFFFF,
  parameter int                CNT_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_vec_i,
  input  logic [SIG_W-1:0]  exp_sig_i,
  output logic [NUM_IN-1:0] x_o,
  input  logic              y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [SIG_W-1:0]  sig_o,
  output logic              pass_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] x_q,     x_d;
  logic [SIG_W-1:0]  sig_q,   sig_d;
  logic [CNT_W-1:0]  rem_q,   rem_d;
  logic [SIG_W-1:0]  exp_q,   exp_d;
  logic              pass_q,  pass_d;

  logic              sig_fb;
  logic [SIG_W-1:0]  sig_step;
  logic [NUM_IN-1:0] x_step;

  // Serial CRC: response bit enters at the MSB feedback point.
  assign sig_fb   = sig_q[SIG_W-1] ^ y_i;
  assign sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_fb ? SIG_POLY : '0);

`ifdef T1_BIST_EXHAUSTIVE_EN
  // Natural overflow gives the wrap from all-ones back to zero.
  assign x_step = x_q + NUM_IN'(1);
`else
  assign x_step = {x_q[NUM_IN-2:0], ^(x_q & LFSR_TAPS)};
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    sig_d   = sig_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          x_d   = SEED;
          sig_d = SIG_INIT;
          rem_d = num_vec_i;
          exp_d = exp_sig_i;
          if (num_vec_i == '0) begin
            // Empty run: signature is just the initial value.
            state_d = ST_DONE;
            pass_d  = (SIG_INIT == exp_sig_i);
          end else begin
            state_d = ST_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        // y_i reflects the x_q presented during this cycle.
        x_d   = x_step;
        sig_d = sig_step;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          // Compare the post-update signature so pass is valid with done.
          pass_d  = (sig_step == exp_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      sig_q   <= SIG_INIT;
      rem_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sig_q   <= sig_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  assign x_o    = x_q;
  assign sig_o  = sig_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign pass_o = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_t1_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t1_bist_driver
//  Purpose  : Self-checking bench for t1_bist_driver. A stand-in cone (random
//             parity of selected inputs, optional inversion) closes the loop;
//             expected stimulus and signatures come from a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t1_bist_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [23:0] num_vec_i;
  logic [15:0] exp_sig_i;
  logic [20:0] x_o;
  logic        y_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] sig_o;
  logic        pass_o;

  logic [20:0] cone_mask;
  logic        cone_inv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign y_i = (^(x_o & cone_mask)) ^ cone_inv;

  t1_bist_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .num_vec_i (num_vec_i),
    .exp_sig_i (exp_sig_i),
    .x_o       (x_o),
    .y_i       (y_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sig_o     (sig_o),
    .pass_o    (pass_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [20:0] next_x(input logic [20:0] x);
`ifdef T1_BIST_EXHAUSTIVE_EN
    return x + 21'd1;
`else
    return {x[19:0], x[20] ^ x[18]};
`endif
  endfunction

  function automatic logic [15:0] crc_bit(input logic [15:0] s, input logic y);
    logic fb;
    fb = s[15] ^ y;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic cone(input logic [20:0] x);
    return (^(x & cone_mask)) ^ cone_inv;
  endfunction

  function automatic logic [15:0] run_signature(input int n);
    logic [20:0] x;
    logic [15:0] s;
    x = 21'h000001;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      s = crc_bit(s, cone(x));
      x = next_x(x);
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"},    32'(x_o),    32'h0);
    chk({tag, "_sig"},  32'(sig_o),  32'hFFFF);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_pass"}, 32'(pass_o), 32'h0);
  endtask

  // Full run; restart_at >= 0 pulses start_i during that RUN cycle.
  task automatic do_run(input int n, input logic [15:0] e, input int restart_at);
    logic [20:0] m_x;
    logic [15:0] m_sig;
    @(negedge clk);
    start_i   = 1'b1;
    num_vec_i = 24'(n);
    exp_sig_i = e;
    @(negedge clk);
    start_i   = 1'b0;
    num_vec_i = 24'd5;
    exp_sig_i = ~e;
    m_x   = 21'h000001;
    m_sig = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      chk("run_busy", 32'(busy_o), 32'h1);
      chk("run_done", 32'(done_o), 32'h0);
      chk("run_x",    32'(x_o),    32'(m_x));
      chk("run_sig",  32'(sig_o),  32'(m_sig));
      start_i = (i == restart_at);
      m_sig = crc_bit(m_sig, cone(m_x));
      m_x   = next_x(m_x);
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("end_done", 32'(done_o), 32'h1);
    chk("end_busy", 32'(busy_o), 32'h0);
    chk("end_sig",  32'(sig_o),  32'(m_sig));
    chk("end_x",    32'(x_o),    32'(m_x));
    chk("end_pass", 32'(pass_o), 32'(m_sig == e));
    @(negedge clk);
    chk("hold_done", 32'(done_o), 32'h1);
    chk("hold_pass", 32'(pass_o), 32'(m_sig == e));
  endtask

  initial begin
    logic [15:0] golden;
    int          n;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    num_vec_i = '0;
    exp_sig_i = '0;
    cone_mask = '0;
    cone_inv  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // Known vectors with the response tied low.
    start_i   = 1'b1;
    num_vec_i = 24'd3;
    exp_sig_i = 16'h0000;
    @(negedge clk);
    start_i = 1'b0;
    chk("t2_x0", 32'(x_o), 32'h000001);
    chk("t2_s0", 32'(sig_o), 32'hFFFF);
    @(negedge clk);
    chk("t2_x1", 32'(x_o), 32'h000002);
    chk("t2_s1", 32'(sig_o), 32'hEFDF);
    chk("t2_d1", 32'(done_o), 32'h0);
    @(negedge clk);
`ifdef T1_BIST_EXHAUSTIVE_EN
    chk("t2_x2", 32'(x_o), 32'h000003);
`else
    chk("t2_x2", 32'(x_o), 32'h000004);
`endif
    chk("t2_s2", 32'(sig_o), 32'hCF9F);
    chk("t2_d2", 32'(done_o), 32'h0);
    @(negedge clk);
    chk("t2_done", 32'(done_o), 32'h1);

    do_run(1, 16'hEFDF, -1);
    chk("t3_pass1", 32'(pass_o), 32'h1);
    do_run(1, 16'h0000, -1);
    chk("t3_pass0", 32'(pass_o), 32'h0);

    // Zero-length run.
    do_run(0, 16'hFFFF, -1);
    chk("t4_pass", 32'(pass_o), 32'h1);
    do_run(0, 16'h1234, -1);

    // Start pulse during RUN is ignored.
    cone_mask = 21'($urandom);
    cone_inv  = 1'($urandom);
    do_run(10, 16'($urandom), 4);
    do_run(10, run_signature(10), 9);

    // Reset in the middle of a run.
    @(negedge clk);
    start_i   = 1'b1;
    num_vec_i = 24'd10;
    exp_sig_i = 16'h0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("post_abort");

    // Randomized runs against the reference.
    for (int r = 0; r < 12; r++) begin
      cone_mask = 21'($urandom);
      cone_inv  = 1'($urandom);
      n         = int'($urandom_range(1, 60));
      golden    = run_signature(n);
      do_run(n, ($urandom_range(0, 1) == 1) ? golden : 16'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
